// File: rtl/myproject_sdiv_seq_23s_7s_16.sv
// ============================================================================
// Module  : myproject_sdiv_seq_23s_7s_16
// Brief   : Sequential signed restoring divider with a saturated quotient and
//           divide-by-zero handling. Optional remainder port: MYPROJECT_SDIV_REM_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module myproject_sdiv_seq_23s_7s_16 #(
    parameter int DIVIDEND_WIDTH = 23,
    parameter int DIVISOR_WIDTH  = 7,
    parameter int QUOT_WIDTH     = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      ap_done,
    output logic                      ap_idle,
    output logic                      ap_ready,
    output logic [QUOT_WIDTH-1:0]     dout,
`ifdef MYPROJECT_SDIV_REM_EN
    output logic [DIVISOR_WIDTH-1:0]  rem_out,
`endif
    output logic                      ovf,
    output logic                      dz
);

    localparam int AW    = DIVIDEND_WIDTH;
    localparam int BW    = DIVISOR_WIDTH;
    localparam int QW    = QUOT_WIDTH;
    localparam int CNT_W = $clog2(AW);

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(AW - 1);
    localparam logic [AW-1:0]    c_pos_lim = AW'((1 << (QW - 1)) - 1);
    localparam logic [AW-1:0]    c_neg_lim = AW'(1 << (QW - 1));
    localparam logic [QW-1:0]    c_q_max   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0]    c_q_min   = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    quo_q, quo_d;
    logic [BW:0]      rem_q, rem_d;
    logic [BW:0]      dvs_q, dvs_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             zero_q, zero_d;
    logic [QW-1:0]    dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
`ifdef MYPROJECT_SDIV_REM_EN
    logic [BW-1:0]    rem_out_q, rem_out_d;
    logic [BW-1:0]    w_rem_fix;
`endif

    // Magnitudes carry one extra bit so the most-negative operands do not wrap.
    logic [AW:0]   w_ext_a, w_abs_a;
    logic [BW:0]   w_ext_b, w_abs_b;
    logic [BW+1:0] w_trial, w_diff;
    logic          w_ge;
    logic          w_neg;
    logic [QW-1:0] w_q_fix;
    logic          w_ovf_fix;

    assign w_ext_a = {din0[AW-1], din0};
    assign w_abs_a = w_ext_a[AW] ? (~w_ext_a + 1'b1) : w_ext_a;
    assign w_ext_b = {din1[BW-1], din1};
    assign w_abs_b = w_ext_b[BW] ? (~w_ext_b + 1'b1) : w_ext_b;

    assign w_trial = {rem_q, quo_q[AW-1]};
    assign w_diff  = w_trial - {1'b0, dvs_q};
    assign w_ge    = (w_trial >= {1'b0, dvs_q});
    assign w_neg   = neg_a_q ^ neg_b_q;

    always_comb begin
        w_ovf_fix = 1'b0;
        w_q_fix   = quo_q[QW-1:0];
        if (zero_q) begin
            w_q_fix = neg_a_q ? c_q_min : c_q_max;
        end else if (w_neg) begin
            if (quo_q > c_neg_lim) begin
                w_q_fix   = c_q_min;
                w_ovf_fix = 1'b1;
            end else begin
                w_q_fix = -quo_q[QW-1:0];
            end
        end else if (quo_q > c_pos_lim) begin
            w_q_fix   = c_q_max;
            w_ovf_fix = 1'b1;
        end
    end

`ifdef MYPROJECT_SDIV_REM_EN
    assign w_rem_fix = zero_q  ? '0 :
                       neg_a_q ? -rem_q[BW-1:0] : rem_q[BW-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        zero_d    = zero_q;
        dout_d    = dout_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
`ifdef MYPROJECT_SDIV_REM_EN
        rem_out_d = rem_out_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    quo_d   = w_abs_a[AW-1:0];
                    rem_d   = '0;
                    dvs_d   = w_abs_b;
                    neg_a_d = din0[AW-1];
                    neg_b_d = din1[BW-1];
                    zero_d  = (din1 == '0);
                end
            end
            CALC: begin
                // Dividend bits shift out of the top while quotient bits enter at the bottom.
                quo_d = {quo_q[AW-2:0], w_ge};
                rem_d = w_ge ? w_diff[BW:0] : w_trial[BW:0];
                if (cnt_q == c_last) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                state_d   = DONE;
                dout_d    = w_q_fix;
                ovf_d     = w_ovf_fix;
                dz_d      = zero_q;
`ifdef MYPROJECT_SDIV_REM_EN
                rem_out_d = w_rem_fix;
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            zero_q    <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
`ifdef MYPROJECT_SDIV_REM_EN
            rem_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            zero_q    <= zero_d;
            dout_q    <= dout_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
`ifdef MYPROJECT_SDIV_REM_EN
            rem_out_q <= rem_out_d;
`endif
        end
    end

    assign ap_done  = (state_q == DONE);
    assign ap_ready = (state_q == DONE);
    assign ap_idle  = (state_q == IDLE);
    assign dout     = dout_q;
    assign ovf      = ovf_q;
    assign dz       = dz_q;
`ifdef MYPROJECT_SDIV_REM_EN
    assign rem_out  = rem_out_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_myproject_sdiv_seq_23s_7s_16.sv
// ============================================================================
// Module  : tb_myproject_sdiv_seq_23s_7s_16
// Brief   : Directed scoreboard bench for the sequential signed divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_myproject_sdiv_seq_23s_7s_16;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic [22:0] din0;
    logic [6:0]  din1;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [15:0] dout;
`ifdef MYPROJECT_SDIV_REM_EN
    logic [6:0]  rem_out;
`endif
    logic        ovf;
    logic        dz;

    myproject_sdiv_seq_23s_7s_16 dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .din0     (din0),
        .din1     (din1),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .dout     (dout),
`ifdef MYPROJECT_SDIV_REM_EN
        .rem_out  (rem_out),
`endif
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int    q;
        int    r;
        int    o;
        int    z;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int b, input string tag);
        exp_t e;
        e.tag = tag;
        if (b == 0) begin
            e.q = (a < 0) ? -32768 : 32767;
            e.r = 0;
            e.o = 0;
            e.z = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.o = 0;
            e.z = 0;
            if (e.q > 32767) begin
                e.q = 32767;
                e.o = 1;
            end else if (e.q < -32768) begin
                e.q = -32768;
                e.o = 1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic check_result();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_dout"}, $signed(dout), e.q);
            chk({e.tag, "_ovf"}, ovf, e.o);
            chk({e.tag, "_dz"}, dz, e.z);
`ifdef MYPROJECT_SDIV_REM_EN
            chk({e.tag, "_rem"}, $signed(rem_out), e.r);
`endif
        end
    endtask

    // Drive a request so it is sampled at the next rising edge; returns #1 after it.
    task automatic start_op(input int a, input int b, input string tag, input bit hold);
        @(negedge ap_clk);
        din0     = a[22:0];
        din1     = b[6:0];
        ap_start = 1'b1;
        push(a, b, tag);
        @(posedge ap_clk);
        #1;
        if (!hold) ap_start = 1'b0;
    endtask

    // Counts rising edges until the one that samples ap_done high.
    task automatic wait_done(output int cyc, output logic rdy, output logic idle_mid);
        logic seen;
        seen     = 1'b0;
        cyc      = 0;
        rdy      = 1'b0;
        idle_mid = 1'bx;
        while (!seen && cyc < 100) begin
            @(negedge ap_clk);
            seen = ap_done;
            if (seen) rdy = ap_ready;
            if (cyc == 12) idle_mid = ap_idle;
            @(posedge ap_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input int a, input int b, input string tag);
        int   cyc;
        logic rdy, idle_mid;
        start_op(a, b, tag, 1'b0);
        wait_done(cyc, rdy, idle_mid);
        chk({tag, "_latency"}, cyc, 25);
        chk({tag, "_ready"}, rdy, 1);
        chk({tag, "_idle_busy"}, idle_mid, 0);
        check_result();
        @(negedge ap_clk);
        chk({tag, "_done_pulse"}, ap_done, 0);
    endtask

    initial begin
        int   cyc;
        int   pulses;
        logic rdy, idle_mid;

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dz", dz, 0);
`ifdef MYPROJECT_SDIV_REM_EN
        chk("rst_rem", rem_out, 0);
`endif

        run_op(1000, 7, "pos_pos");
        run_op(-1000, 7, "neg_pos");
        run_op(100, -64, "min_divisor");
        run_op(-4194304, -1, "min_dividend_sat");
        run_op(4194303, 1, "max_dividend_sat");
        run_op(2097152, -64, "neg_edge_no_sat");
        run_op(-4194304, -64, "pos_sat_minmin");
        run_op(3, 7, "zero_quot");
        run_op(-5, 0, "dz_neg");
        run_op(5, 0, "dz_pos");

        // Reset on the 10th CALC cycle: abort without a done pulse.
        start_op(1000, 7, "aborted", 1'b0);
        repeat (9) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        sb.delete();
        @(negedge ap_clk);
        chk("abort_idle", ap_idle, 1);
        chk("abort_dout", dout, 0);
        chk("abort_dz", dz, 0);
        chk("abort_ovf", ovf, 0);
`ifdef MYPROJECT_SDIV_REM_EN
        chk("abort_rem", rem_out, 0);
`endif
        pulses = 0;
        repeat (30) begin
            @(negedge ap_clk);
            if (ap_done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        run_op(1000, 7, "after_abort");

        // Reset wins over a simultaneous start.
        @(negedge ap_clk);
        ap_rst   = 1'b1;
        ap_start = 1'b1;
        din0     = 23'd50;
        din1     = 7'd3;
        @(posedge ap_clk);
        #1;
        ap_rst   = 1'b0;
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk("rst_priority_idle", ap_idle, 1);

        // Start held high, operands changed mid-flight.
        start_op(1000, 7, "held_first", 1'b1);
        din0 = 23'd2000;
        wait_done(cyc, rdy, idle_mid);
        chk("held_first_latency", cyc, 25);
        check_result();
        push(2000, 7, "held_second");
        wait_done(cyc, rdy, idle_mid);
        ap_start = 1'b0;
        chk("held_second_spacing", cyc, 26);
        check_result();
        pulses = 0;
        repeat (30) begin
            @(negedge ap_clk);
            if (ap_done) pulses++;
        end
        chk("held_stop_no_done", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/myproject_sdiv_seq_23s_7s_16.md
MYPROJECT_SDIV_SEQ_23S_7S_16 -- requirements
Module: myproject_sdiv_seq_23s_7s_16

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 23, dividend width in bits.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 7, divisor and remainder width in bits.
REQ-003 SHALL have parameter QUOT_WIDTH, default 16, saturated quotient width in bits.
REQ-004 SHALL have ap_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have ap_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ap_start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have din0  input  23  signed dividend.
REQ-008 SHALL have din1  input  7  signed divisor.
REQ-009 SHALL have ap_done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have ap_idle  output  1  high while in IDLE.
REQ-011 SHALL have ap_ready  output  1  asserted in the same cycle as ap_done.
REQ-012 SHALL have dout  output  16  signed saturated quotient.
REQ-013 SHALL have rem_out  output  7  signed remainder (present only per REQ-030).
REQ-014 SHALL have ovf  output  1  quotient saturated.
REQ-015 SHALL have dz  output  1  divisor was zero.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX, DONE: IDLE->CALC on ap_start=1; CALC->FIX after 23 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-017 SHALL capture din0 and din1 on the IDLE->CALC edge; input changes after that edge have no effect on the operation in flight.
REQ-018 SHALL perform an unsigned restoring division of |din0| by |din1|, one quotient bit per CALC cycle, MSB first, using an internal counter of 0..22.
REQ-019 SHALL produce truncating (round-toward-zero) results: quotient negative iff operand signs differ and the quotient magnitude is nonzero; remainder sign equal to the dividend sign; |remainder| < |divisor|.
REQ-020 SHALL, in FIX, saturate quotients above 32767 to 32767 and below -32768 to -32768, and set ovf=1 when saturation occurs.
REQ-021 SHALL, for din1=0, return dout=32767 for din0>=0 and -32768 for din0<0, with rem_out=0, dz=1, ovf=0, and identical latency.
REQ-022 SHALL assert ap_done and ap_ready for exactly one cycle, 25 rising edges after the edge at which ap_start was sampled high in IDLE.
REQ-023 SHALL register dout, rem_out, ovf and dz, update them only on the FIX->DONE edge, and hold them until the next FIX->DONE edge.
REQ-024 SHALL keep ap_idle=0 from CALC through DONE; ap_start held high continuously starts a new operation on the first IDLE cycle after DONE (throughput one result per 26 cycles).
REQ-025 SHALL handle the most-negative divisor -64 and the most-negative dividend -4194304 without internal overflow; absolute-value datapaths are one bit wider than the operand.

Reset
REQ-026 SHALL, with ap_rst=1 at a rising edge, enter IDLE and clear the iteration counter.
REQ-027 SHALL reset the outputs to ap_done=0, ap_ready=0, ap_idle=1, dout=0, rem_out=0, ovf=0, dz=0.
REQ-028 SHALL abort any operation in flight on reset, with no ap_done pulse for that operation.
REQ-029 SHALL give ap_rst priority over ap_start in the same cycle.

Configuration
REQ-030 SHALL define macro MYPROJECT_SDIV_REM_EN: when defined, the rem_out port and remainder sign fix-up are built; when undefined, rem_out is absent, the remainder register is not kept past CALC, and all other behaviour and latency are unchanged.

Verification
REQ-031 SHALL cover din0=1000, din1=7 -> dout=142, rem_out=6, ovf=0, dz=0, ap_done 25 edges after start.
REQ-032 SHALL cover din0=-1000, din1=7 -> dout=-142, rem_out=-6; and din0=100, din1=-64 -> dout=-1, rem_out=36.
REQ-033 SHALL cover din0=-4194304, din1=-1 -> dout=32767, ovf=1, rem_out=0; and din0=4194303, din1=1 -> dout=32767, ovf=1.
REQ-034 SHALL cover din0=-5, din1=0 -> dout=-32768, dz=1, rem_out=0, ovf=0, same latency.
REQ-035 SHALL cover ap_rst asserted on the 10th CALC cycle -> next cycle ap_idle=1, all outputs 0, no ap_done pulse; a following start of 1000/7 completes normally.
REQ-036 SHALL cover ap_start held high with din0 changed mid-operation -> first result reflects the captured operands; a second ap_done pulse follows 26 cycles after the first.
